// File: rtl/ysyx_25060170_ifu_fetch_if.sv
// Instruction-memory port between the fetch unit and memory:
// a request channel and a response channel, each with a valid/ready handshake.
interface ysyx_25060170_ifu_fetch_if;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic        imem_resp_ready;
   logic [31:0] imem_resp_data;
   logic        imem_resp_err;

   modport master (
      output imem_req_valid, imem_req_addr, imem_resp_ready,
      input  imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, imem_resp_ready,
      output imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err
   );
endinterface

// File: rtl/ysyx_25060170_ifu_fetch.sv
// Fetch unit: owns the fetch PC, keeps one request in flight on the imem port,
// and presents each returned instruction to decode. Redirects squash in-flight work.
module ysyx_25060170_ifu_fetch #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input  logic                               clk,
   input  logic                               rst,
   ysyx_25060170_ifu_fetch_if.master          imem,
   input  logic                               redirect_valid,
   input  logic [31:0]                        redirect_pc,
   input  logic                               id_allowin,
   output logic                               if_valid,
   output logic [31:0]                        if_inst,
   output logic [31:0]                        if_pc,
   output logic                               if_err,
   output logic [31:0]                        fetch_cnt
);

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

   state_t      state, state_nxt;
   logic [31:0] fetch_pc, fetch_pc_nxt;
   logic        capture;
   logic        deliver;
   logic        squash;

   always_comb begin
      state_nxt            = state;
      capture              = 1'b0;
      deliver              = 1'b0;
      squash               = 1'b0;
      imem.imem_req_valid  = 1'b0;
      imem.imem_resp_ready = 1'b0;
      imem.imem_req_addr   = fetch_pc;
      case (state)
         S_REQ: begin
            imem.imem_req_valid = 1'b1;
            if (imem.imem_req_ready)
               state_nxt = redirect_valid ? S_DROP : S_WAIT;
         end
         S_WAIT: begin
            imem.imem_resp_ready = 1'b1;
            if (imem.imem_resp_valid) begin
               if (redirect_valid) begin
                  state_nxt = S_REQ;
               end else begin
                  capture   = 1'b1;
                  state_nxt = S_HOLD;
               end
            end else if (redirect_valid) begin
               state_nxt = S_DROP;
            end
         end
         S_HOLD: begin
            if (redirect_valid) begin
               squash    = 1'b1;
               state_nxt = S_REQ;
            end else if (id_allowin) begin
               deliver   = 1'b1;
               state_nxt = S_REQ;
            end
         end
         S_DROP: begin
            imem.imem_resp_ready = 1'b1;
            if (imem.imem_resp_valid)
               state_nxt = S_REQ;
         end
         default: state_nxt = S_REQ;
      endcase
      // Handshake strobes stay low during the reset cycle regardless of the stale state.
      if (rst) begin
         imem.imem_req_valid  = 1'b0;
         imem.imem_resp_ready = 1'b0;
      end
      if (redirect_valid)
         fetch_pc_nxt = redirect_pc;
      else if (deliver)
         fetch_pc_nxt = fetch_pc + PC_STEP;
      else
         fetch_pc_nxt = fetch_pc;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_REQ;
         fetch_pc  <= RESET_PC;
         if_valid  <= 1'b0;
         if_inst   <= '0;
         if_pc     <= '0;
         if_err    <= 1'b0;
         fetch_cnt <= '0;
      end else begin
         state    <= state_nxt;
         fetch_pc <= fetch_pc_nxt;
         if (capture) begin
            if_valid <= 1'b1;
            if_inst  <= imem.imem_resp_data;
            if_err   <= imem.imem_resp_err;
            if_pc    <= fetch_pc;
         end else if (deliver || squash) begin
            if_valid <= 1'b0;
         end
         if (deliver)
            fetch_cnt <= fetch_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_ysyx_25060170_ifu_fetch.sv
// Bench for ysyx_25060170_ifu_fetch: cycle vector table, directed redirect/error/reset
// sequences, then random traffic against a transaction-level PC/count reference.
module tb_ysyx_25060170_ifu_fetch;

   localparam logic [31:0] A0 = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_allowin;
   logic        if_valid;
   logic [31:0] if_inst;
   logic [31:0] if_pc;
   logic        if_err;
   logic [31:0] fetch_cnt;

   int unsigned n_pass = 0;
   int unsigned n_tot  = 0;

   ysyx_25060170_ifu_fetch_if bus ();

   ysyx_25060170_ifu_fetch #(.RESET_PC(32'h8000_0000), .PC_STEP(32'd4)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem           (bus),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_allowin     (id_allowin),
      .if_valid       (if_valid),
      .if_inst        (if_inst),
      .if_pc          (if_pc),
      .if_err         (if_err),
      .fetch_cnt      (fetch_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memfn(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   function automatic logic errfn(input logic [31:0] a);
      return a[6:2] == 5'h04;
   endfunction

   typedef struct {
      logic        rst, rqr, rsv;
      logic [31:0] data;
      logic        err, redir;
      logic [31:0] rpc;
      logic        allow;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_rsr, e_ifv;
      logic [31:0] e_pc, e_inst;
      logic        e_err;
      logic [31:0] e_cnt;
   } vec_t;

   function automatic vec_t mk(input logic r, rqr, rsv, input logic [31:0] d, input logic er,
                               input logic rd, input logic [31:0] rp, input logic al,
                               input logic eq, input logic [31:0] ea, input logic ers, eiv,
                               input logic [31:0] ep, ei, input logic ee, input logic [31:0] ec);
      vec_t v;
      v.rst = r; v.rqr = rqr; v.rsv = rsv; v.data = d; v.err = er; v.redir = rd; v.rpc = rp;
      v.allow = al; v.e_req = eq; v.e_addr = ea; v.e_rsr = ers; v.e_ifv = eiv; v.e_pc = ep;
      v.e_inst = ei; v.e_err = ee; v.e_cnt = ec;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Set inputs just after the falling edge; outputs are sampled 1ns later.
   task automatic drive(input logic r, rqr, rsv, input logic [31:0] d, input logic er,
                        input logic rd, input logic [31:0] rp, input logic al);
      @(negedge clk);
      rst = r; bus.imem_req_ready = rqr; bus.imem_resp_valid = rsv; bus.imem_resp_data = d;
      bus.imem_resp_err = er; redirect_valid = rd; redirect_pc = rp; id_allowin = al;
      #1;
   endtask

   vec_t tbl[16];

   initial begin
      logic [31:0] mpc, mcnt, paddr, rpc;
      logic        pending, rqr, rsv, rerr, redir, allow;
      logic [31:0] rdata;
      int unsigned lat, idle;

      rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; id_allowin = 1'b0;
      bus.imem_req_ready = 1'b0; bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data = '0; bus.imem_resp_err = 1'b0;
      repeat (2) drive(1, 0, 0, 0, 0, 0, 0, 0);

      tbl[0]  = mk(1,0,0,0,0,0,0,0,          0,0,0,     0,0,0,0,0);
      tbl[1]  = mk(0,1,0,0,0,0,0,1,          1,A0,0,    0,0,0,0,0);
      tbl[2]  = mk(0,1,1,memfn(A0),0,0,0,1,  0,0,1,     0,0,0,0,0);
      tbl[3]  = mk(0,1,0,0,0,0,0,1,          0,0,0,     1,A0,memfn(A0),0,0);
      tbl[4]  = mk(0,1,0,0,0,0,0,1,          1,A0+4,0,  0,0,0,0,1);
      tbl[5]  = mk(0,1,1,memfn(A0+4),0,0,0,1,0,0,1,     0,0,0,0,1);
      tbl[6]  = mk(0,1,0,0,0,0,0,1,          0,0,0,     1,A0+4,memfn(A0+4),0,1);
      tbl[7]  = mk(0,1,0,0,0,0,0,1,          1,A0+8,0,  0,0,0,0,2);
      tbl[8]  = mk(0,1,1,memfn(A0+8),0,0,0,0,0,0,1,     0,0,0,0,2);
      for (int unsigned i = 9; i <= 13; i++)
         tbl[i] = mk(0,1,0,0,0,0,0,0,        0,0,0,     1,A0+8,memfn(A0+8),0,2);
      tbl[14] = mk(0,1,0,0,0,0,0,1,          0,0,0,     1,A0+8,memfn(A0+8),0,2);
      tbl[15] = mk(0,1,0,0,0,0,0,1,          1,A0+12,0, 0,0,0,0,3);

      for (int unsigned i = 0; i < 16; i++) begin
         drive(tbl[i].rst, tbl[i].rqr, tbl[i].rsv, tbl[i].data, tbl[i].err,
               tbl[i].redir, tbl[i].rpc, tbl[i].allow);
         chk($sformatf("T%0d_req_valid", i), bus.imem_req_valid, tbl[i].e_req);
         chk($sformatf("T%0d_resp_ready", i), bus.imem_resp_ready, tbl[i].e_rsr);
         chk($sformatf("T%0d_if_valid", i), if_valid, tbl[i].e_ifv);
         chk($sformatf("T%0d_fetch_cnt", i), fetch_cnt, tbl[i].e_cnt);
         if (tbl[i].e_req) chk($sformatf("T%0d_req_addr", i), bus.imem_req_addr, tbl[i].e_addr);
         if (tbl[i].e_ifv) begin
            chk($sformatf("T%0d_if_pc", i), if_pc, tbl[i].e_pc);
            chk($sformatf("T%0d_if_inst", i), if_inst, tbl[i].e_inst);
            chk($sformatf("T%0d_if_err", i), if_err, tbl[i].e_err);
         end
      end

      // Redirect while waiting; the response arrives two cycles later and must be dropped.
      drive(0, 0, 0, 0, 0, 1, 32'h8000_1000, 0);
      chk("A_resp_ready", bus.imem_resp_ready, 1);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      chk("A_drop_resp_ready", bus.imem_resp_ready, 1);
      drive(0, 0, 1, memfn(A0+12), 0, 0, 0, 0);
      chk("A_if_valid_drop", if_valid, 0);
      drive(0, 1, 0, 0, 0, 0, 0, 0);
      chk("A_req_valid", bus.imem_req_valid, 1);
      chk("A_req_addr", bus.imem_req_addr, 32'h8000_1000);
      chk("A_if_valid", if_valid, 0);
      chk("A_fetch_cnt", fetch_cnt, 3);

      // Redirect coinciding with id_allowin in HOLD.
      drive(0, 0, 1, memfn(32'h8000_1000), 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 1, A0+16, 1);
      chk("B_if_valid", if_valid, 1);
      chk("B_if_pc", if_pc, 32'h8000_1000);
      drive(0, 1, 0, 0, 0, 0, 0, 0);
      chk("B_if_valid_squash", if_valid, 0);
      chk("B_fetch_cnt", fetch_cnt, 3);
      chk("B_req_addr", bus.imem_req_addr, A0+16);

      // Access fault delivered like a normal instruction, then sequential fetch continues.
      drive(0, 0, 1, memfn(A0+16), 1, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 1);
      chk("C_if_valid", if_valid, 1);
      chk("C_if_pc", if_pc, A0+16);
      chk("C_if_err", if_err, 1);
      drive(0, 1, 0, 0, 0, 0, 0, 0);
      chk("C_req_addr", bus.imem_req_addr, A0+20);
      chk("C_fetch_cnt", fetch_cnt, 4);
      drive(0, 0, 1, memfn(A0+20), 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      chk("C_if_pc2", if_pc, A0+20);
      chk("C_if_err2", if_err, 0);
      chk("C_if_inst2", if_inst, memfn(A0+20));

      // Reset while waiting with a response on the bus.
      drive(0, 0, 0, 0, 0, 0, 0, 1);
      drive(0, 1, 0, 0, 0, 0, 0, 0);
      chk("D_req_addr", bus.imem_req_addr, A0+24);
      drive(1, 0, 1, memfn(A0+24), 0, 0, 0, 0);
      chk("D_rst_req_valid", bus.imem_req_valid, 0);
      chk("D_rst_resp_ready", bus.imem_resp_ready, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      chk("D_if_valid", if_valid, 0);
      chk("D_if_pc", if_pc, 0);
      chk("D_if_inst", if_inst, 0);
      chk("D_fetch_cnt", fetch_cnt, 0);
      chk("D_req_valid", bus.imem_req_valid, 1);
      chk("D_req_addr2", bus.imem_req_addr, A0);
      drive(0, 1, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 1, memfn(A0), 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      chk("D_if_inst2", if_inst, memfn(A0));

      // Random traffic: reference tracks architectural fetch PC and delivered count only.
      repeat (2) drive(1, 0, 0, 0, 0, 0, 0, 0);
      mpc = A0; mcnt = 0; pending = 0; paddr = 0; lat = 0; idle = 0;
      for (int unsigned cyc = 0; cyc < 4000; cyc++) begin
         rqr = ($urandom_range(0, 3) != 0);
         rsv = 1'b0; rdata = $urandom; rerr = $urandom_range(0, 1) != 0;
         if (pending) begin
            if (lat == 0) begin
               rsv = 1'b1; rdata = memfn(paddr); rerr = errfn(paddr);
            end else begin
               lat--;
            end
         end
         redir = ($urandom_range(0, 9) == 0);
         case ($urandom_range(0, 3))
            0:       rpc = 32'hFFFF_FFF8;
            1:       rpc = A0 + ($urandom_range(0, 255) << 2);
            2:       rpc = $urandom;
            default: rpc = A0 + 32'h100;
         endcase
         allow = ($urandom_range(0, 2) != 0);
         drive(0, rqr, rsv, rdata, rerr, redir, rpc, allow);

         chk("R_fetch_cnt", fetch_cnt, mcnt);
         idle++;
         if (rsv && bus.imem_resp_ready) pending = 1'b0;
         if (bus.imem_req_valid && rqr) begin
            chk("R_one_outstanding", {31'b0, pending}, 0);
            chk("R_req_addr", bus.imem_req_addr, mpc);
            pending = 1'b1; paddr = bus.imem_req_addr; lat = $urandom_range(0, 3);
            idle = 0;
         end
         if (if_valid && allow && !redir) begin
            chk("R_if_pc", if_pc, mpc);
            chk("R_if_inst", if_inst, memfn(mpc));
            chk("R_if_err", if_err, errfn(mpc));
            mpc  = mpc + 32'd4;
            mcnt = mcnt + 32'd1;
            idle = 0;
         end
         if (redir) mpc = rpc;
         if (idle > 40) begin
            chk("R_stall_cycles", idle, 0);
            break;
         end
      end
      chk("R_any_delivered", {31'b0, mcnt != 0}, 1);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
